// File: rtl/intrapred_pkg.sv
// -----------------------------------------------------------------------------
// intrapred_pkg
// Shared definitions for the intra-prediction controller:
//   - controller state encoding
//   - mode width and the field layout of the packed per-macroblock mode word
//   - macroblock / sub-block index widths
//   - pack_modes(): assembles the downstream mode word from its fields
// -----------------------------------------------------------------------------
package intrapred_pkg;

    // Width of every individual mode decision.
    localparam int MODE_W  = 3;

    // Field layout of modes_out: sixteen luma 4x4 modes from bit 0 upward,
    // then luma 16x16, chroma-B and chroma-R.
    localparam int L4_BASE = 0;
    localparam int L16_LSB = 48;
    localparam int CB_LSB  = 51;
    localparam int CR_LSB  = 54;
    localparam int MODES_W = 57;

    // Index widths.
    localparam int MB_W    = 13;
    localparam int NUM_BLK = 16;
    localparam int BLK_W   = 4;
    localparam int L4_W    = NUM_BLK * MODE_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_PRED4  = 3'd2,
        ST_PRED16 = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    // Assemble the downstream mode word from the captured fields.
    function automatic logic [MODES_W-1:0] pack_modes(
        input logic [L4_W-1:0]   l4_flat,
        input logic [MODE_W-1:0] l16,
        input logic [MODE_W-1:0] cb,
        input logic [MODE_W-1:0] cr
    );
        logic [MODES_W-1:0] w;
        w                        = '0;
        w[L4_BASE +: L4_W]       = l4_flat;
        w[L16_LSB +: MODE_W]     = l16;
        w[CB_LSB  +: MODE_W]     = cb;
        w[CR_LSB  +: MODE_W]     = cr;
        return w;
    endfunction

endpackage

// File: rtl/intrapred_ctrl_if.sv
// -----------------------------------------------------------------------------
// intrapred_ctrl_if
// Bundles every non-clock signal of the intra-prediction controller.
//   master : the controller (drives indices, enables and the output handshake)
//   slave  : the environment (frame control, mode decisions, downstream ready)
// Signals:
//   start, abort            frame control into the controller
//   mode_luma4x4/16x16      luma mode decisions from the sader/saver chain
//   mode_chromab/chromar    chroma mode decisions
//   out_ready               downstream acceptance of modes_out
//   mbnumber, blkidx        current macroblock and 4x4 sub-block
//   fetch_en, en_*          per-stage enables into the datapath
//   out_valid, modes_out    packed modes handed downstream
//   mb_done, frame_done     completion pulses
//   busy                    high whenever the controller is not idle
// -----------------------------------------------------------------------------
interface intrapred_ctrl_if;
    import intrapred_pkg::*;

    logic                start;
    logic                abort;
    logic [MODE_W-1:0]   mode_luma4x4;
    logic [MODE_W-1:0]   mode_luma16x16;
    logic [MODE_W-1:0]   mode_chromab;
    logic [MODE_W-1:0]   mode_chromar;
    logic                out_ready;

    logic [MB_W-1:0]     mbnumber;
    logic [BLK_W-1:0]    blkidx;
    logic                fetch_en;
    logic                en_luma4x4;
    logic                en_luma16x16;
    logic                en_chroma;
    logic                out_valid;
    logic [MODES_W-1:0]  modes_out;
    logic                mb_done;
    logic                frame_done;
    logic                busy;

    modport master (
        input  start, abort,
        input  mode_luma4x4, mode_luma16x16, mode_chromab, mode_chromar,
        input  out_ready,
        output mbnumber, blkidx,
        output fetch_en, en_luma4x4, en_luma16x16, en_chroma,
        output out_valid, modes_out, mb_done, frame_done, busy
    );

    modport slave (
        output start, abort,
        output mode_luma4x4, mode_luma16x16, mode_chromab, mode_chromar,
        output out_ready,
        input  mbnumber, blkidx,
        input  fetch_en, en_luma4x4, en_luma16x16, en_chroma,
        input  out_valid, modes_out, mb_done, frame_done, busy
    );

endinterface

// File: rtl/intrapred_ctrl.sv
// -----------------------------------------------------------------------------
// intrapred_ctrl
// Walks the intra-prediction datapath through a frame one macroblock at a time:
// fetch the macroblock and its neighbours, run the sixteen luma 4x4 predictions,
// run the luma 16x16 and chroma predictions together, then offer the packed
// modes downstream on a valid/ready handshake.
//
// Parameters:
//   FRAME_MBS  macroblocks per frame (1..8192)
//   FETCH_LAT  cycles fetch_en is held per macroblock (>= 1)
//   PIPE_LAT   cycles from a prediction enable to a valid mode input (>= 1)
//
// Ports:
//   clk    clock
//   reset  asynchronous active-high reset
//   bus    controller side of intrapred_ctrl_if (see the interface header)
//
// Every output comes straight from a register. Enable-style outputs are
// registered from the next-state decode so they line up with the state.
// -----------------------------------------------------------------------------
module intrapred_ctrl
    import intrapred_pkg::*;
#(
    parameter int FRAME_MBS = 396,
    parameter int FETCH_LAT = 2,
    parameter int PIPE_LAT  = 3
) (
    input  logic             clk,
    input  logic             reset,
    intrapred_ctrl_if.master bus
);

    // The cycle counter is shared by FETCH and both prediction phases.
    localparam int CNT_MAX = (FETCH_LAT > PIPE_LAT) ? FETCH_LAT : PIPE_LAT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_LAT - 1);
    localparam logic [CNT_W-1:0] PIPE_LAST  = CNT_W'(PIPE_LAT - 1);
    localparam logic [MB_W-1:0]  MB_LAST    = MB_W'(FRAME_MBS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(NUM_BLK - 1);

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [MB_W-1:0]    mbnumber_q,   mbnumber_d;
    logic [BLK_W-1:0]   blkidx_q,     blkidx_d;
    logic               fetch_en_q,   fetch_en_d;
    logic               en_l4_q,      en_l4_d;
    logic               en_l16_q,     en_l16_d;
    logic               en_chroma_q,  en_chroma_d;
    logic               out_valid_q,  out_valid_d;
    logic               mb_done_q,    mb_done_d;
    logic               frame_done_q, frame_done_d;
    logic               busy_q,       busy_d;

    // Mode capture bank: one entry per luma 4x4 sub-block plus the tail modes.
    logic [MODE_W-1:0]  l4_q [NUM_BLK];
    logic [MODE_W-1:0]  l16_q;
    logic [MODE_W-1:0]  cb_q;
    logic [MODE_W-1:0]  cr_q;
    logic               l4_we;
    logic               tail_we;
    logic [L4_W-1:0]    l4_flat;

    // ------------------------------------------------------------------------
    // Next-state, capture strobes and next-output decode
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        mbnumber_d   = mbnumber_q;
        blkidx_d     = blkidx_q;
        mb_done_d    = 1'b0;
        frame_done_d = 1'b0;
        l4_we        = 1'b0;
        tail_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_FETCH;
                    mbnumber_d = '0;
                    blkidx_d   = '0;
                    cnt_d      = '0;
                end
            end

            ST_FETCH: begin
                if (cnt_q == FETCH_LAST) begin
                    state_d  = ST_PRED4;
                    blkidx_d = '0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_PRED4: begin
                // The mode for the current sub-block is valid on the last
                // cycle of its PIPE_LAT window.
                if (cnt_q == PIPE_LAST) begin
                    l4_we = 1'b1;
                    cnt_d = '0;
                    if (blkidx_q == BLK_LAST) begin
                        // blkidx stays at 15 until the next FETCH entry.
                        state_d = ST_PRED16;
                    end else begin
                        blkidx_d = blkidx_q + BLK_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_PRED16: begin
                if (cnt_q == PIPE_LAST) begin
                    tail_we = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_OUT: begin
                // modes_out, mbnumber and blkidx only change on acceptance,
                // so they stay stable under backpressure.
                if (bus.out_ready) begin
                    mb_done_d = 1'b1;
                    if (mbnumber_q == MB_LAST) begin
                        frame_done_d = 1'b1;
                        mbnumber_d   = '0;
                        state_d      = ST_IDLE;
                    end else begin
                        mbnumber_d = mbnumber_q + MB_W'(1);
                        blkidx_d   = '0;
                        cnt_d      = '0;
                        state_d    = ST_FETCH;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a same-cycle start or
        // acceptance; captured modes are left untouched.
        if (bus.abort) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            mbnumber_d   = '0;
            blkidx_d     = '0;
            mb_done_d    = 1'b0;
            frame_done_d = 1'b0;
            l4_we        = 1'b0;
            tail_we      = 1'b0;
        end

        // Enables and status follow the state being entered.
        fetch_en_d  = (state_d == ST_FETCH);
        en_l4_d     = (state_d == ST_PRED4);
        en_l16_d    = (state_d == ST_PRED16);
        en_chroma_d = (state_d == ST_PRED16);
        out_valid_d = (state_d == ST_OUT);
        busy_d      = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values present before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mbnumber_q   <= '0;
            blkidx_q     <= '0;
            fetch_en_q   <= 1'b0;
            en_l4_q      <= 1'b0;
            en_l16_q     <= 1'b0;
            en_chroma_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            mb_done_q    <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mbnumber_q   <= mbnumber_d;
            blkidx_q     <= blkidx_d;
            fetch_en_q   <= fetch_en_d;
            en_l4_q      <= en_l4_d;
            en_l16_q     <= en_l16_d;
            en_chroma_q  <= en_chroma_d;
            out_valid_q  <= out_valid_d;
            mb_done_q    <= mb_done_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    // NOTE: this capture bank drives modes_out directly and must read 0 after
    // reset, so it is reset like ordinary flops rather than left as a RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BLK; i++) begin
                l4_q[i] <= '0;
            end
            l16_q <= '0;
            cb_q  <= '0;
            cr_q  <= '0;
        end else begin
            if (l4_we) begin
                l4_q[blkidx_q] <= bus.mode_luma4x4;
            end
            if (tail_we) begin
                l16_q <= bus.mode_luma16x16;
                cb_q  <= bus.mode_chromab;
                cr_q  <= bus.mode_chromar;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        l4_flat = '0;
        for (int i = 0; i < NUM_BLK; i++) begin
            l4_flat[i*MODE_W +: MODE_W] = l4_q[i];
        end
    end

    assign bus.modes_out    = pack_modes(l4_flat, l16_q, cb_q, cr_q);
    assign bus.mbnumber     = mbnumber_q;
    assign bus.blkidx       = blkidx_q;
    assign bus.fetch_en     = fetch_en_q;
    assign bus.en_luma4x4   = en_l4_q;
    assign bus.en_luma16x16 = en_l16_q;
    assign bus.en_chroma    = en_chroma_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.mb_done      = mb_done_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_intrapred_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intrapred_ctrl
// Self-checking bench for intrapred_ctrl (FRAME_MBS=2, FETCH_LAT=2, PIPE_LAT=3).
// A timeline model tracks where each macroblock is in its schedule as a plain
// cycle offset and derives every expected output from that offset; a compare
// process checks all outputs against it on every falling edge. Directed
// stimulus adds literal expectations at hand-computed cycle numbers, where
// cycle 0 is the cycle in which start is sampled.
// -----------------------------------------------------------------------------
module tb_intrapred_ctrl;
    import intrapred_pkg::*;

    localparam int N_MBS = 2;
    localparam int FL    = 2;
    localparam int PL    = 3;
    localparam int T_P4  = FL;            // first PRED4 offset
    localparam int T_P16 = FL + 16 * PL;  // first PRED16 offset
    localparam int T_OUT = FL + 17 * PL;  // OUT offset

    logic clk   = 1'b0;
    logic reset = 1'b1;

    intrapred_ctrl_if bus ();

    intrapred_ctrl #(
        .FRAME_MBS (N_MBS),
        .FETCH_LAT (FL),
        .PIPE_LAT  (PL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Timeline model
    // ------------------------------------------------------------------------
    bit         m_busy;
    int         m_t;         // cycle offset inside the current macroblock
    int         m_mb;
    int         m_blk;
    bit         m_mb_done;
    bit         m_frame_done;
    logic [2:0] e_l4 [16];
    logic [2:0] e_l16, e_cb, e_cr;
    int         seed;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_t = 0; m_mb = 0; m_blk = 0;
            m_mb_done = 0; m_frame_done = 0;
            foreach (e_l4[i]) e_l4[i] = '0;
            e_l16 = '0; e_cb = '0; e_cr = '0;
        end else begin
            m_mb_done    = 0;
            m_frame_done = 0;
            if (bus.abort) begin
                m_busy = 0; m_mb = 0; m_blk = 0;
            end else if (!m_busy) begin
                if (bus.start) begin
                    m_busy = 1; m_t = 0; m_mb = 0;
                end
            end else begin
                if (m_t >= T_P4 && m_t < T_P16 && ((m_t - T_P4) % PL) == PL - 1)
                    e_l4[(m_t - T_P4) / PL] = bus.mode_luma4x4;
                if (m_t == T_OUT - 1) begin
                    e_l16 = bus.mode_luma16x16;
                    e_cb  = bus.mode_chromab;
                    e_cr  = bus.mode_chromar;
                end
                if (m_t == T_OUT) begin
                    if (bus.out_ready) begin
                        m_mb_done = 1;
                        if (m_mb == N_MBS - 1) begin
                            m_frame_done = 1; m_busy = 0; m_mb = 0;
                        end else begin
                            m_mb++; m_t = 0;
                        end
                    end
                end else begin
                    m_t++;
                end
            end
            if (m_busy)
                m_blk = (m_t < T_P4) ? 0 : (m_t < T_P16) ? (m_t - T_P4) / PL : 15;
        end
    end

    function automatic logic [63:0] model_word();
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < 16; k++) w = w | (64'(e_l4[k]) << (3 * k));
        w = w | (64'(e_l16) << 48) | (64'(e_cb) << 51) | (64'(e_cr) << 54);
        return w;
    endfunction

    always @(negedge clk) begin
        check("busy",         64'(bus.busy),         64'(m_busy));
        check("fetch_en",     64'(bus.fetch_en),     64'(m_busy && m_t < T_P4));
        check("en_luma4x4",   64'(bus.en_luma4x4),   64'(m_busy && m_t >= T_P4 && m_t < T_P16));
        check("en_luma16x16", 64'(bus.en_luma16x16), 64'(m_busy && m_t >= T_P16 && m_t < T_OUT));
        check("en_chroma",    64'(bus.en_chroma),    64'(m_busy && m_t >= T_P16 && m_t < T_OUT));
        check("out_valid",    64'(bus.out_valid),    64'(m_busy && m_t == T_OUT));
        check("mbnumber",     64'(bus.mbnumber),     64'(m_mb));
        check("blkidx",       64'(bus.blkidx),       64'(m_blk));
        check("mb_done",      64'(bus.mb_done),      64'(m_mb_done));
        check("frame_done",   64'(bus.frame_done),   64'(m_frame_done));
        check("modes_out",    64'(bus.modes_out),    model_word());
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    int now;

    // Advance one falling edge at a time; the 4x4 mode input follows the
    // sub-block the schedule says is active.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            now++;
            bus.mode_luma4x4 = 3'((m_blk + seed) % 8);
        end
    endtask

    task automatic go(input int c);
        if (c > now) step(c - now);
    endtask

    task automatic begin_frame(input int s, input logic [2:0] l16,
                               input logic [2:0] cb, input logic [2:0] cr);
        seed               = s;
        bus.mode_luma16x16 = l16;
        bus.mode_chromab   = cb;
        bus.mode_chromar   = cr;
        bus.start          = 1'b1;
        now                = 0;
        step(1);
        bus.start          = 1'b0;
    endtask

    initial begin
        bus.start          = 1'b0;
        bus.abort          = 1'b0;
        bus.mode_luma4x4   = '0;
        bus.mode_luma16x16 = '0;
        bus.mode_chromab   = '0;
        bus.mode_chromar   = '0;
        bus.out_ready      = 1'b1;
        seed               = 0;
        now                = 0;

        // Reset state
        step(2);
        check("rst_busy",  64'(bus.busy),      64'd0);
        check("rst_modes", 64'(bus.modes_out), 64'd0);
        check("rst_mb",    64'(bus.mbnumber),  64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        reset = 1'b0;
        step(1);

        // Frame 1: free-running timing and mode capture
        begin_frame(0, 3'd2, 3'd1, 3'd3);
        go(1);   check("f1_fetch_c1", 64'(bus.fetch_en), 64'd1);
                 check("f1_busy_c1",  64'(bus.busy),     64'd1);
        go(2);   check("f1_fetch_c2", 64'(bus.fetch_en), 64'd1);
        go(3);   check("f1_en4_c3",   64'(bus.en_luma4x4), 64'd1);
                 check("f1_fetch_c3", 64'(bus.fetch_en),   64'd0);
                 check("f1_blk_c3",   64'(bus.blkidx),     64'd0);
        go(6);   check("f1_blk_c6",   64'(bus.blkidx),     64'd1);
        go(50);  check("f1_en4_c50",  64'(bus.en_luma4x4), 64'd1);
                 check("f1_blk_c50",  64'(bus.blkidx),     64'd15);
        go(51);  check("f1_en4_c51",  64'(bus.en_luma4x4), 64'd0);
                 check("f1_en16_c51", 64'(bus.en_luma16x16), 64'd1);
                 check("f1_ench_c51", 64'(bus.en_chroma),  64'd1);
        go(53);  check("f1_en16_c53", 64'(bus.en_luma16x16), 64'd1);
        go(54);  check("f1_valid_c54", 64'(bus.out_valid), 64'd1);
                 check("f1_modes_c54", 64'(bus.modes_out), 64'(57'o3127654321076543210));
        go(55);  check("f1_done_c55",  64'(bus.mb_done),    64'd1);
                 check("f1_fdone_c55", 64'(bus.frame_done), 64'd0);
                 check("f1_mb_c55",    64'(bus.mbnumber),   64'd1);
                 check("f1_fetch_c55", 64'(bus.fetch_en),   64'd1);
        go(109); check("f1_fdone_c109", 64'(bus.frame_done), 64'd1);
                 check("f1_busy_c109",  64'(bus.busy),       64'd0);
        go(110);

        // Frame 2: backpressure on the first macroblock
        bus.out_ready = 1'b0;
        begin_frame(3, 3'd5, 3'd6, 3'd7);
        go(54);  check("f2_valid_c54", 64'(bus.out_valid), 64'd1);
                 check("f2_modes_c54", 64'(bus.modes_out), 64'(57'o7652107654321076543));
        go(64);  check("f2_valid_c64", 64'(bus.out_valid), 64'd1);
                 check("f2_mb_c64",    64'(bus.mbnumber),  64'd0);
                 check("f2_modes_c64", 64'(bus.modes_out), 64'(57'o7652107654321076543));
                 check("f2_done_c64",  64'(bus.mb_done),   64'd0);
        bus.out_ready = 1'b1;
        go(65);  check("f2_done_c65",  64'(bus.mb_done),    64'd1);
                 check("f2_mb_c65",    64'(bus.mbnumber),   64'd1);
                 check("f2_fetch_c65", 64'(bus.fetch_en),   64'd1);
                 check("f2_fdone_c65", 64'(bus.frame_done), 64'd0);
        go(119); check("f2_fdone_c119", 64'(bus.frame_done), 64'd1);
                 check("f2_busy_c119",  64'(bus.busy),       64'd0);
        go(120);

        // Frame 3: start while busy, abort at blkidx 7, start+abort in IDLE
        begin_frame(5, 3'd1, 3'd2, 3'd4);
        go(10);  bus.start = 1'b1;
        go(11);  bus.start = 1'b0;
                 check("f3_en4_c11", 64'(bus.en_luma4x4), 64'd1);
                 check("f3_blk_c11", 64'(bus.blkidx),     64'd2);
        go(25);  check("f3_blk_c25", 64'(bus.blkidx),     64'd7);
        bus.abort = 1'b1;
        go(26);  bus.abort = 1'b0;
                 check("f3_busy_abort",  64'(bus.busy),       64'd0);
                 check("f3_en4_abort",   64'(bus.en_luma4x4), 64'd0);
                 check("f3_mb_abort",    64'(bus.mbnumber),   64'd0);
                 check("f3_blk_abort",   64'(bus.blkidx),     64'd0);
                 check("f3_done_abort",  64'(bus.mb_done),    64'd0);
        go(27);  check("f3_done_c27",    64'(bus.mb_done),    64'd0);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        go(28);  bus.start = 1'b0;
                 bus.abort = 1'b0;
                 check("f3_busy_sa",  64'(bus.busy),     64'd0);
                 check("f3_fetch_sa", 64'(bus.fetch_en), 64'd0);
        go(29);

        // Clean run after abort, with an ignored start in the second macroblock
        begin_frame(5, 3'd1, 3'd2, 3'd4);
        go(1);   check("f3b_mb_c1",    64'(bus.mbnumber), 64'd0);
                 check("f3b_fetch_c1", 64'(bus.fetch_en), 64'd1);
        go(55);  check("f3b_done_c55", 64'(bus.mb_done),  64'd1);
                 check("f3b_mb_c55",   64'(bus.mbnumber), 64'd1);
        go(60);  bus.start = 1'b1;
        go(61);  bus.start = 1'b0;
        go(109); check("f3b_fdone_c109", 64'(bus.frame_done), 64'd1);
                 check("f3b_busy_c109",  64'(bus.busy),       64'd0);
        go(110);

        // Frame 4: asynchronous reset between edges during PRED16
        begin_frame(6, 3'd3, 3'd3, 3'd3);
        go(52);  check("f4_en16_c52", 64'(bus.en_luma16x16), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("f4_arst_busy",  64'(bus.busy),         64'd0);
        check("f4_arst_en16",  64'(bus.en_luma16x16), 64'd0);
        check("f4_arst_ench",  64'(bus.en_chroma),    64'd0);
        check("f4_arst_modes", 64'(bus.modes_out),    64'd0);
        check("f4_arst_blk",   64'(bus.blkidx),       64'd0);
        check("f4_arst_done",  64'(bus.mb_done),      64'd0);
        step(1);
        reset = 1'b0;
        step(1);

        // Resume after reset
        begin_frame(7, 3'd0, 3'd7, 3'd5);
        go(54);  check("f5_valid_c54", 64'(bus.out_valid), 64'd1);
                 check("f5_modes_c54", 64'(bus.modes_out), 64'(57'o5706543210765432107));
        go(55);  check("f5_done_c55",  64'(bus.mb_done),   64'd1);
        go(109); check("f5_fdone_c109", 64'(bus.frame_done), 64'd1);
        go(111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
